fifo_rd_stream: RTL and testbench
=================================

Name: fifo_rd_stream

Overview:
Read-side adapter placed directly downstream of fifo_sync. It drains the FIFO through its rd_en/dout/empty port, which has one cycle of read latency. It presents the data as a first-word-fall-through valid/ready stream to the next stage. A 3-entry output buffer sustains one word per cycle under continuous m_ready and loses no data under backpressure, with no combinational path from m_ready to fifo_rd_en.

Parameters:
DATA_WIDTH, 8, width of FIFO words and stream data.

Ports:
clk  input  1  system clock; all state updates on rising edge.
rst  input  1  reset, asynchronous, active-high; same net as fifo_sync rst.
fifo_empty  input  1  empty flag from fifo_sync.
fifo_rd_en  output  1  read strobe to fifo_sync.
fifo_dout  input  DATA_WIDTH  read data from fifo_sync; valid the cycle after fifo_rd_en was sampled high.
m_data  output  DATA_WIDTH  stream data (head of buffer).
m_valid  output  1  stream data valid.
m_ready  input  1  downstream accepts m_data this cycle.
occupancy  output  2  number of words held in buffer, 0..3.

Behaviour:
- State:
  - 3-entry ring buffer with wr_ptr and rd_ptr (mod 3).
  - count register, 0..3.
  - inflight register: a FIFO read was issued in the previous cycle.
- Reset values (applied asynchronously while rst=1):
  - count=0, inflight=0, pointers=0, buffer contents=0.
  - m_valid=0, m_data=0, occupancy=0, fifo_rd_en=0.
- fifo_rd_en:
  - Combinational: fifo_rd_en = !rst && !fifo_empty && (count + inflight <= 2).
  - Never depends on m_ready.
- inflight:
  - Next value = fifo_rd_en.
  - When inflight=1, fifo_dout is written into the buffer at wr_ptr on the next edge; wr_ptr advances.
- Pop:
  - pop = m_valid && m_ready.
  - On pop, rd_ptr advances at the edge.
  - m_valid=0 means no pop, regardless of m_ready.
- Count update: count_next = count + inflight - pop.
  - Simultaneous arrival and pop keep count unchanged.
  - Arrival into an empty buffer while m_ready=1 does not pop in the same cycle: no bypass, data appears on m_valid next cycle.
- Outputs:
  - m_valid = (count != 0).
  - m_data = buffer[rd_ptr]; held stable while m_valid && !m_ready.
  - occupancy = count.
- Latency: fifo_rd_en high in cycle N -> fifo_dout valid in N+1 -> m_valid high in N+2 when buffer was empty.
- Throughput: with m_ready held at 1 and the FIFO non-empty, steady state is count=1, inflight=1, one word per cycle.
- Boundaries:
  - count + inflight never exceeds 3; the buffer cannot overflow.
  - count=0 with a pop attempt is impossible because m_valid=0.
  - Wrap-around: pointers 2 -> 0.
  - fifo_empty rising while inflight=1: the inflight word is still captured.
- Reset mid-operation: buffer and inflight word discarded; m_valid drops immediately; no fifo_rd_en while rst=1.
- Ordering: words leave in exactly the order read from the FIFO.
- No word is duplicated or dropped.

Test Plan:
1. Reset -> while rst=1 and one cycle after release with FIFO empty: m_valid=0, fifo_rd_en=0, occupancy=0, m_data=0.
2. Write 15 bytes 0x10..0x1E into fifo_sync, m_ready=1 throughout -> first fifo_rd_en within 1 cycle of empty=0; m_valid 2 cycles after first read; bytes 0x10..0x1E on consecutive cycles after startup, in order; fifo_empty=1 and occupancy=0 at end.
3. Load 8 bytes 0x20..0x27, m_ready=0 -> exactly 3 fifo_rd_en pulses, occupancy=3, m_data=0x20 held stable. Then m_ready=1 -> 0x20..0x27 in order, no gaps after refill.
4. Load 15 bytes 0x30..0x3E; m_ready toggles 1,0,0,1,1,0,... -> accepted sequence is exactly 0x30..0x3E; occupancy never exceeds 3; m_data stable whenever m_valid && !m_ready.
5. Load 5 bytes; assert rst one cycle after the second read is issued -> m_valid=0 immediately, occupancy=0, inflight word not delivered after release; FIFO and adapter both empty.
6. Write a single byte 0x55 while m_ready=1 -> exactly one fifo_rd_en pulse, one m_valid cycle carrying 0x55, then m_valid=0 and fifo_rd_en stays 0.

Source files
------------

// File: rtl/fifo_rd_stream.sv
// Read-side adapter for fifo_sync: turns the one-cycle-latency rd_en/dout port
// into a first-word-fall-through valid/ready stream through a 3-entry ring buffer.
module fifo_rd_stream #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fifo_empty,
  output logic                  fifo_rd_en,
  input  logic [DATA_WIDTH-1:0] fifo_dout,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [1:0]            occupancy
);

  logic [DATA_WIDTH-1:0] buf_q [3];
  logic [1:0]            wr_ptr_q, wr_ptr_d;
  logic [1:0]            rd_ptr_q, rd_ptr_d;
  logic [1:0]            count_q, count_d;
  logic                  inflight_q;
  logic                  pop;
  logic [2:0]            committed;

  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  // A read is issued only if the word it returns is guaranteed a free slot,
  // counting the word already in flight; m_ready is deliberately excluded.
  always_comb begin
    committed  = {1'b0, count_q} + {2'b00, inflight_q};
    fifo_rd_en = !rst && !fifo_empty && (committed <= 3'd2);
  end

  always_comb begin
    pop      = m_valid && m_ready;
    wr_ptr_d = inflight_q ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    count_d  = count_q;
    case ({inflight_q, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < 3; i++) buf_q[i] <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      inflight_q <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < 3; i++) begin
        if (inflight_q && (wr_ptr_q == 2'(i))) buf_q[i] <= fifo_dout;
      end
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      inflight_q <= fifo_rd_en;
    end
  end

  always_comb begin
    m_valid   = (count_q != 2'd0);
    occupancy = count_q;
    case (rd_ptr_q)
      2'd1:    m_data = buf_q[1];
      2'd2:    m_data = buf_q[2];
      default: m_data = buf_q[0];
    endcase
  end

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Bench for fifo_rd_stream: fifo_sync modelled as a queue, adapter checked
// against an in-order word queue with occupancy derived from word counts.
module tb_fifo_rd_stream;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, fifo_empty, fifo_rd_en, m_valid, m_ready;
  logic [7:0] fifo_dout, m_data;
  logic [1:0] occupancy;

  int checks = 0;
  int errors = 0;

  logic [7:0] fq[$];    // contents of fifo_sync
  logic [7:0] expq[$];  // words read from fifo_sync, not yet accepted downstream
  logic [7:0] acc[$];   // words accepted downstream
  logic [7:0] wq[$];    // words written into fifo_sync
  logic       inflight_m = 1'b0;
  int         nrd = 0, nvalid = 0, max_occ = 0;
  logic       last_rd = 1'b0, last_valid = 1'b0;
  logic       hold_prev = 1'b0;
  logic [7:0] hold_data = 8'h00;

  fifo_rd_stream #(.DATA_WIDTH(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .fifo_empty (fifo_empty),
    .fifo_rd_en (fifo_rd_en),
    .fifo_dout  (fifo_dout),
    .m_data     (m_data),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .occupancy  (occupancy)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic put(input logic [7:0] d);
    fq.push_back(d);
    wq.push_back(d);
    fifo_empty = 1'b0;
  endtask

  // One clock cycle: check outputs against the word-level model, then advance it.
  task automatic cycle();
    int         occ;
    logic       vexp, rd;
    logic [7:0] w;
    w = 8'h00;
    #1;
    occ  = expq.size() - int'(inflight_m);
    vexp = (occ != 0);
    check("rd_en", 16'(fifo_rd_en), 16'(!rst && fq.size() != 0 && expq.size() <= 2));
    check("m_valid", 16'(m_valid), 16'(vexp));
    check("occupancy", 16'(occupancy), 16'(occ));
    if (vexp) check("m_data", 16'(m_data), 16'(expq[0]));
    if (hold_prev) check("m_data_hold", 16'(m_data), 16'(hold_data));
    if (occ > max_occ) max_occ = occ;
    hold_prev  = vexp && !m_ready;
    hold_data  = m_data;
    last_valid = m_valid;
    if (m_valid) nvalid++;
    if (vexp && m_ready) acc.push_back(expq.pop_front());
    rd      = fifo_rd_en;
    last_rd = rd;
    if (rd) nrd++;
    if (rd && fq.size() != 0) begin
      w = fq.pop_front();
      expq.push_back(w);
    end
    @(posedge clk);
    #1;
    if (rd) fifo_dout = w;
    inflight_m = rd;
    fifo_empty = (fq.size() == 0);
  endtask

  task automatic check_stream(input string tag);
    check({tag, "_len"}, 16'(acc.size()), 16'(wq.size()));
    for (int i = 0; i < acc.size() && i < wq.size(); i++)
      check({tag, "_word"}, 16'(acc[i]), 16'(wq[i]));
    acc.delete();
    wq.delete();
  endtask

  initial begin
    int first_rd, first_valid;
    rst        = 1'b1;
    fifo_empty = 1'b1;
    fifo_dout  = 8'h00;
    m_ready    = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", 16'(m_valid), 16'(0));
    check("rst_rd_en", 16'(fifo_rd_en), 16'(0));
    check("rst_occ", 16'(occupancy), 16'(0));
    check("rst_data", 16'(m_data), 16'(0));
    rst = 1'b0;
    cycle();
    check("post_rst_data", 16'(m_data), 16'(0));

    // Continuous streaming with latency checks
    m_ready = 1'b1;
    for (int b = 8'h10; b <= 8'h1E; b++) put(8'(b));
    first_rd    = -1;
    first_valid = -1;
    for (int c = 0; c < 25; c++) begin
      cycle();
      if (last_rd && first_rd < 0) first_rd = c;
      if (last_valid && first_valid < 0) first_valid = c;
    end
    check("s2_first_rd", 16'(first_rd), 16'(0));
    check("s2_first_valid", 16'(first_valid), 16'(first_rd + 2));
    check("s2_empty", 16'(fifo_empty), 16'(1));
    check("s2_occ_end", 16'(occupancy), 16'(0));
    check_stream("s2");

    // Backpressure fill, then drain without gaps
    m_ready = 1'b0;
    nrd = 0;
    for (int b = 8'h20; b <= 8'h27; b++) put(8'(b));
    repeat (6) cycle();
    check("s3_reads", 16'(nrd), 16'(3));
    check("s3_occ", 16'(occupancy), 16'(3));
    check("s3_head", 16'(m_data), 16'(8'h20));
    m_ready = 1'b1;
    nvalid = 0;
    repeat (8) cycle();
    check("s3_no_gap", 16'(nvalid), 16'(8));
    repeat (4) cycle();
    check_stream("s3");

    // Toggling ready pattern 1,0,0,1,1,0,...
    max_occ = 0;
    for (int b = 8'h30; b <= 8'h3E; b++) put(8'(b));
    for (int c = 0; c < 60; c++) begin
      case (c % 6)
        0, 3, 4: m_ready = 1'b1;
        default: m_ready = 1'b0;
      endcase
      cycle();
    end
    m_ready = 1'b1;
    repeat (4) cycle();
    check("s4_max_occ", 16'(max_occ <= 3), 16'(1));
    check_stream("s4");

    // Reset while a word is in flight
    nrd = 0;
    for (int b = 0; b < 5; b++) put(8'(8'hA0 + b));
    for (int c = 0; c < 10 && nrd < 2; c++) cycle();
    check("s5_two_reads", 16'(nrd), 16'(2));
    cycle();
    rst = 1'b1;
    #1;
    check("s5_valid_drop", 16'(m_valid), 16'(0));
    check("s5_occ", 16'(occupancy), 16'(0));
    check("s5_rd_en", 16'(fifo_rd_en), 16'(0));
    check("s5_data", 16'(m_data), 16'(0));
    fq.delete();
    expq.delete();
    acc.delete();
    wq.delete();
    inflight_m = 1'b0;
    fifo_empty = 1'b1;
    hold_prev  = 1'b0;
    repeat (2) cycle();
    rst = 1'b0;
    nvalid = 0;
    repeat (5) cycle();
    check("s5_no_delivery", 16'(nvalid), 16'(0));
    check("s5_acc", 16'(acc.size()), 16'(0));

    // Single word
    m_ready = 1'b1;
    nrd = 0;
    nvalid = 0;
    put(8'h55);
    repeat (6) cycle();
    check("s6_reads", 16'(nrd), 16'(1));
    check("s6_valids", 16'(nvalid), 16'(1));
    check("s6_valid_end", 16'(m_valid), 16'(0));
    check("s6_rd_end", 16'(fifo_rd_en), 16'(0));
    check_stream("s6");

    // Random writes and ready
    max_occ = 0;
    for (int c = 0; c < 400; c++) begin
      m_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 2) == 0) put(8'($urandom));
      cycle();
    end
    m_ready = 1'b1;
    for (int c = 0; c < 200 && (fq.size() != 0 || expq.size() != 0); c++) cycle();
    repeat (2) cycle();
    check("rnd_max_occ", 16'(max_occ <= 3), 16'(1));
    check("rnd_occ_end", 16'(occupancy), 16'(0));
    check_stream("rnd");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
